rv32_instr_encoder: RTL and testbench
=====================================

// Module: rv32_instr_encoder
// PURPOSE
// Encoder side of the RV32I instruction format: turns structured encode requests
// (op class, registers, funct3, alt bit, 32-bit immediate) into 32-bit RV32I words.
// Expands the LI pseudo-op into LUI/ADDI pairs. Sits in the debug/boot injection
// path and feeds the fetch-side instruction stream through a valid/ready handshake.
// PARAMETERS
// FIFO_DEPTH  2  request FIFO entries; power of two, >= 2
// PORTS
// clk           in   1   clock; all state updates on rising edge
// rst           in   1   synchronous, active-high reset
// req_valid     in   1   encode request present
// req_ready     out  1   request FIFO can accept
// req_op        in   4   0 LUI,1 AUIPC,2 JAL,3 JALR,4 BRANCH,5 OP_IMM,6 OP,7 STORE,8 LOAD,9 LI; else invalid
// req_rd        in   5   destination register
// req_rs1       in   5   source register 1
// req_rs2       in   5   source register 2
// req_funct3    in   3   funct3 field (ignored for LUI/AUIPC/JAL/LI)
// req_alt       in   1   funct7[5]: SUB/SRA for OP, SRAI for OP_IMM funct3=101
// req_imm       in   32  immediate; byte offset for JAL/BRANCH; full value for LUI/AUIPC/LI
// instr_valid   out  1   instr holds a word
// instr_ready   in   1   consumer takes word
// instr         out  32  encoded instruction
// instr_last    out  1   final word of the current request
// instr_err     out  1   request rejected; instr is NOP 32'h0000_0013
// BEHAVIOUR
// - Reset: req_ready=0 in the reset cycle, then 1. instr_valid=0, instr=32'h0000_0013,
//   instr_last=0, instr_err=0. FIFO flushed. FSM=IDLE. Any pending second LI word is dropped.
// - Input: a request is accepted when req_valid&&req_ready. req_ready=!fifo_full
//   (registered count only, no pass-through). A push and pop may occur in the same cycle.
// - Output register: loads when !instr_valid || instr_ready. instr, instr_last and instr_err
//   stay stable while instr_valid&&!instr_ready.
// - Latency: a request accepted on edge k into an empty FIFO, with the output free,
//   gives instr_valid=1 after edge k+1. Sustained rate is 1 word/cycle.
// - FSM IDLE->EMIT: FIFO non-empty and output loadable. Pop the head and emit word 1.
//   A single-word op goes back to IDLE, or stays in EMIT if the FIFO holds another entry.
//   LI needing two words goes EMIT->EMIT2 with no pop. EMIT2 emits ADDI on load, then
//   continues as EMIT.
// - Formats (opcode): LUI 0x37 U, AUIPC 0x17 U (imm[31:12]), JAL 0x6F J (imm[20:1]),
//   JALR 0x67 I funct3=0, BRANCH 0x63 B (imm[12:1]), OP_IMM 0x13 I, OP 0x33 R
//   (funct7={1'b0,alt,5'b0}), STORE 0x23 S, LOAD 0x03 I.
// - OP_IMM shifts (funct3 001/101): imm field={1'b0,alt,5'b0,imm[4:0]}.
// - LI: if imm in [-2048,2047], one word ADDI rd,x0,imm.
//   Else hi=(imm+32'h800)>>12, a 32-bit wrap is allowed; emit LUI rd,hi, then
//   ADDI rd,rd,imm[11:0] only if imm[11:0]!=0.
// - Errors (single NOP word, instr_err=1, instr_last=1):
//   - JAL/BRANCH with imm[0]=1.
//   - JAL with imm outside +-1MiB; BRANCH outside +-4KiB.
//   - I/S-type imm outside the 12-bit signed range (OP_IMM non-shift, JALR, LOAD, STORE).
//   - Shift with imm[31:5]!=0.
//   - Invalid op.
//   U-type ignores imm[11:0]. rd=0 is encoded as given, with no suppression.
// - instr_last=1 on every word except LUI of a two-word LI.
// TESTING
// - LI x5,0x12345678 -> 0x123452B7 (last=0), then 0x67828293 (last=1).
// - LI x5,0x12345FFF -> 0x123462B7, then 0xFFF28293. LI x5,0x7000 -> 0x000072B7 only,
//   last=1. LI x5,-5 -> 0xFFB00293.
// - OP x3,x1,x2 f3=0 alt=0 -> 0x002081B3; alt=1 -> 0x402081B3.
//   BEQ x1,x2,+8 -> 0x00208463. SW x2,4(x1) -> 0x0020A223.
// - JAL imm=3, then op=12 -> two NOPs 0x00000013 with err=1, and the FIFO keeps flowing.
// - Backpressure: hold instr_ready=0 for 5 cycles mid-LI -> word stable, FIFO fills,
//   req_ready=0. On release, all words come out in order with no loss or duplication.
// - Assert rst while in EMIT2 -> next cycle instr_valid=0, FIFO empty, no ADDI emitted.

Source files
------------

// File: rtl/rv32_instr_encoder.sv
// rv32_instr_encoder: turns structured encode requests into RV32I words.
// Requests queue in a small FIFO; the LI pseudo-op expands to LUI/ADDI pairs.
// The output register feeds the fetch-side stream through a valid/ready handshake.
module rv32_instr_encoder #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [2:0]  req_funct3,
    input  logic        req_alt,
    input  logic [31:0] req_imm,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic        instr_last,
    output logic        instr_err
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [31:0] Nop = 32'h0000_0013;

    localparam logic [3:0] OpLui    = 4'd0;
    localparam logic [3:0] OpAuipc  = 4'd1;
    localparam logic [3:0] OpJal    = 4'd2;
    localparam logic [3:0] OpJalr   = 4'd3;
    localparam logic [3:0] OpBranch = 4'd4;
    localparam logic [3:0] OpOpImm  = 4'd5;
    localparam logic [3:0] OpOp     = 4'd6;
    localparam logic [3:0] OpStore  = 4'd7;
    localparam logic [3:0] OpLoad   = 4'd8;
    localparam logic [3:0] OpLi     = 4'd9;

    localparam logic [6:0] OpcLui    = 7'h37;
    localparam logic [6:0] OpcAuipc  = 7'h17;
    localparam logic [6:0] OpcJal    = 7'h6F;
    localparam logic [6:0] OpcJalr   = 7'h67;
    localparam logic [6:0] OpcBranch = 7'h63;
    localparam logic [6:0] OpcOpImm  = 7'h13;
    localparam logic [6:0] OpcOp     = 7'h33;
    localparam logic [6:0] OpcStore  = 7'h23;
    localparam logic [6:0] OpcLoad   = 7'h03;

    typedef enum logic [1:0] {StIdle, StEmit, StEmit2} state_e;

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        alt;
        logic [31:0] imm;
    } req_t;

    req_t            fifo_mem [FIFO_DEPTH];
    req_t            req_in;
    req_t            head;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            in_reset_q;
    state_e          state_q;
    logic            instr_valid_q, instr_last_q, instr_err_q;
    logic [31:0]     instr_q;

    logic            fifo_empty, fifo_full, push, pop, out_load;
    logic [31:0]     enc_word1, enc_word2;
    logic            enc_two, enc_err;
    logic [19:0]     li_hi;
    logic            imm_i12_ok, imm_b_ok, imm_j_ok, is_shift;

    assign req_in     = '{op: req_op, rd: req_rd, rs1: req_rs1, rs2: req_rs2,
                          funct3: req_funct3, alt: req_alt, imm: req_imm};
    assign head       = fifo_mem[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    // Ready comes from registered state only, and stays low for the reset cycle.
    assign req_ready  = !in_reset_q && !fifo_full;
    assign push       = req_valid && req_ready;
    assign out_load   = !instr_valid_q || instr_ready;
    // A two-word LI keeps its entry until the ADDI half goes out.
    assign pop        = out_load && ((state_q == StEmit2) || (!fifo_empty && !enc_two));
    assign count_d    = count_q + CntW'(push) - CntW'(pop);

    // Signed-range checks: all bits above the field's sign bit must match it.
    assign imm_i12_ok = (&head.imm[31:11]) || !(|head.imm[31:11]);
    assign imm_b_ok   = (&head.imm[31:12]) || !(|head.imm[31:12]);
    assign imm_j_ok   = (&head.imm[31:20]) || !(|head.imm[31:20]);
    assign is_shift   = (head.funct3[1:0] == 2'b01);
    // (imm + 0x800) >> 12 rounds so the sign-extended ADDI low part lands exactly.
    assign li_hi      = head.imm[31:12] + {19'd0, head.imm[11]};

    // Combinational encode of the FIFO head.
    always_comb begin
        enc_word1 = Nop;
        enc_word2 = {head.imm[11:0], head.rd, 3'b000, head.rd, OpcOpImm};
        enc_two   = 1'b0;
        enc_err   = 1'b0;
        case (head.op)
            OpLui:   enc_word1 = {head.imm[31:12], head.rd, OpcLui};
            OpAuipc: enc_word1 = {head.imm[31:12], head.rd, OpcAuipc};
            OpJal: begin
                enc_err   = head.imm[0] || !imm_j_ok;
                enc_word1 = {head.imm[20], head.imm[10:1], head.imm[11], head.imm[19:12],
                             head.rd, OpcJal};
            end
            OpJalr: begin
                enc_err   = !imm_i12_ok;
                enc_word1 = {head.imm[11:0], head.rs1, 3'b000, head.rd, OpcJalr};
            end
            OpBranch: begin
                enc_err   = head.imm[0] || !imm_b_ok;
                enc_word1 = {head.imm[12], head.imm[10:5], head.rs2, head.rs1, head.funct3,
                             head.imm[4:1], head.imm[11], OpcBranch};
            end
            OpOpImm: begin
                if (is_shift) begin
                    enc_err   = |head.imm[31:5];
                    enc_word1 = {1'b0, head.alt, 5'b0, head.imm[4:0], head.rs1, head.funct3,
                                 head.rd, OpcOpImm};
                end else begin
                    enc_err   = !imm_i12_ok;
                    enc_word1 = {head.imm[11:0], head.rs1, head.funct3, head.rd, OpcOpImm};
                end
            end
            OpOp: enc_word1 = {1'b0, head.alt, 5'b0, head.rs2, head.rs1, head.funct3,
                               head.rd, OpcOp};
            OpStore: begin
                enc_err   = !imm_i12_ok;
                enc_word1 = {head.imm[11:5], head.rs2, head.rs1, head.funct3, head.imm[4:0],
                             OpcStore};
            end
            OpLoad: begin
                enc_err   = !imm_i12_ok;
                enc_word1 = {head.imm[11:0], head.rs1, head.funct3, head.rd, OpcLoad};
            end
            OpLi: begin
                if (imm_i12_ok) begin
                    enc_word1 = {head.imm[11:0], 5'd0, 3'b000, head.rd, OpcOpImm};
                end else begin
                    enc_word1 = {li_hi, head.rd, OpcLui};
                    enc_two   = |head.imm[11:0];
                end
            end
            default: enc_err = 1'b1;
        endcase
        if (enc_err) begin
            enc_word1 = Nop;
            enc_two   = 1'b0;
        end
    end

    // FIFO storage write; contents need no reset since pointers gate them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= req_in;
        end
    end

    // FIFO pointers, emit FSM and registered output word.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_reset_q    <= 1'b1;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= StIdle;
            instr_valid_q <= 1'b0;
            instr_q       <= Nop;
            instr_last_q  <= 1'b0;
            instr_err_q   <= 1'b0;
        end else begin
            in_reset_q <= 1'b0;
            count_q    <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (out_load) begin
                if (state_q == StEmit2) begin
                    instr_valid_q <= 1'b1;
                    instr_q       <= enc_word2;
                    instr_last_q  <= 1'b1;
                    instr_err_q   <= 1'b0;
                    state_q       <= (count_d != '0) ? StEmit : StIdle;
                end else if (!fifo_empty) begin
                    instr_valid_q <= 1'b1;
                    instr_q       <= enc_word1;
                    instr_last_q  <= !enc_two;
                    instr_err_q   <= enc_err;
                    if (enc_two) begin
                        state_q <= StEmit2;
                    end else begin
                        state_q <= (count_d != '0) ? StEmit : StIdle;
                    end
                end else begin
                    instr_valid_q <= 1'b0;
                    state_q       <= StIdle;
                end
            end
        end
    end

    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_last  = instr_last_q;
    assign instr_err   = instr_err_q;

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// tb_rv32_instr_encoder: directed vectors for the RV32I encoder.
module tb_rv32_instr_encoder;
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int OP_LUI = 0, OP_JAL = 2, OP_BRANCH = 4, OP_OPIMM = 5, OP_OP = 6;
    localparam int OP_STORE = 7, OP_LI = 9, OP_BAD = 12;

    logic        clk, rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [2:0]  req_funct3;
    logic        req_alt;
    logic [31:0] req_imm;
    logic        instr_valid, instr_ready, instr_last, instr_err;
    logic [31:0] instr;

    int checks = 0;
    int failures = 0;
    logic [33:0] got_q[$];

    rv32_instr_encoder #(.FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_rd      (req_rd),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_funct3  (req_funct3),
        .req_alt     (req_alt),
        .req_imm     (req_imm),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_last  (instr_last),
        .instr_err   (instr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every word that will hand off on the coming rising edge.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            got_q.push_back({instr_err, instr_last, instr});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic present(input int op, input int rd, input int rs1, input int rs2,
                           input int f3, input int alt, input logic [31:0] imm);
        req_valid  = 1'b1;
        req_op     = op[3:0];
        req_rd     = rd[4:0];
        req_rs1    = rs1[4:0];
        req_rs2    = rs2[4:0];
        req_funct3 = f3[2:0];
        req_alt    = alt[0];
        req_imm    = imm;
    endtask

    // Hold a request until accepted (bounded), then drop req_valid.
    task automatic send(input int op, input int rd, input int rs1, input int rs2,
                        input int f3, input int alt, input logic [31:0] imm);
        int n;
        n = 0;
        present(op, rd, rs1, rs2, f3, alt, imm);
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_accept", 36'(req_ready), 36'(1'b1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] w, input logic last,
                               input logic err);
        int n;
        logic [33:0] obs;
        n = 0;
        while (got_q.size() == 0 && n < 50) begin
            step();
            n++;
        end
        if (got_q.size() == 0) obs = 'x;
        else obs = got_q.pop_front();
        check(tag, 36'(obs), 36'({err, last, w}));
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
        req_funct3 = '0; req_alt = 1'b0; req_imm = '0;
        instr_ready = 1'b1;
        step();
        step();
        check("rst_req_ready", 36'(req_ready), 36'(1'b0));
        check("rst_instr_valid", 36'(instr_valid), 36'(1'b0));
        check("rst_instr", 36'(instr), 36'(NOP));
        check("rst_last_err", 36'({instr_last, instr_err}), 36'(2'b00));
        rst = 1'b0;
        step();
        check("ready_after_rst", 36'(req_ready), 36'(1'b1));

        // Latency: valid appears one edge after acceptance.
        send(OP_OP, 3, 1, 2, 0, 0, 32'd0);
        check("lat_edge_k", 36'(instr_valid), 36'(1'b0));
        step();
        check("lat_edge_k1", 36'(instr_valid), 36'(1'b1));
        expect_word("op_add", 32'h0020_81B3, 1'b1, 1'b0);

        // Single-word formats.
        send(OP_OP, 3, 1, 2, 0, 1, 32'd0);
        send(OP_BRANCH, 0, 1, 2, 0, 0, 32'd8);
        send(OP_STORE, 0, 1, 2, 2, 0, 32'd4);
        send(OP_LUI, 7, 0, 0, 0, 0, 32'hABCD_E123);
        send(OP_JAL, 1, 0, 0, 0, 0, 32'h0000_0800);
        send(OP_OPIMM, 4, 4, 0, 5, 1, 32'd3);
        expect_word("op_sub", 32'h4020_81B3, 1'b1, 1'b0);
        expect_word("beq", 32'h0020_8463, 1'b1, 1'b0);
        expect_word("sw", 32'h0020_A223, 1'b1, 1'b0);
        expect_word("lui", 32'hABCD_E3B7, 1'b1, 1'b0);
        expect_word("jal", 32'h0010_00EF, 1'b1, 1'b0);
        expect_word("srai", 32'h4032_5213, 1'b1, 1'b0);

        // LI expansion.
        send(OP_LI, 5, 0, 0, 0, 0, 32'h1234_5678);
        send(OP_LI, 5, 0, 0, 0, 0, 32'h1234_5FFF);
        send(OP_LI, 5, 0, 0, 0, 0, 32'h0000_7000);
        send(OP_LI, 5, 0, 0, 0, 0, 32'hFFFF_FFFB);
        expect_word("li1_lui", 32'h1234_52B7, 1'b0, 1'b0);
        expect_word("li1_addi", 32'h6782_8293, 1'b1, 1'b0);
        expect_word("li2_lui", 32'h1234_62B7, 1'b0, 1'b0);
        expect_word("li2_addi", 32'hFFF2_8293, 1'b1, 1'b0);
        expect_word("li3_lui_only", 32'h0000_72B7, 1'b1, 1'b0);
        expect_word("li4_addi", 32'hFFB0_0293, 1'b1, 1'b0);

        // Rejected requests become NOPs and the stream keeps flowing.
        send(OP_JAL, 1, 0, 0, 0, 0, 32'd3);
        send(OP_BAD, 1, 0, 0, 0, 0, 32'd0);
        send(OP_OPIMM, 1, 1, 0, 0, 0, 32'd2048);
        send(OP_BRANCH, 0, 1, 2, 0, 0, 32'd4096);
        send(OP_OPIMM, 1, 1, 0, 1, 0, 32'd32);
        send(OP_OP, 3, 1, 2, 0, 0, 32'd0);
        expect_word("err_jal_odd", NOP, 1'b1, 1'b1);
        expect_word("err_bad_op", NOP, 1'b1, 1'b1);
        expect_word("err_addi_range", NOP, 1'b1, 1'b1);
        expect_word("err_branch_range", NOP, 1'b1, 1'b1);
        expect_word("err_shamt", NOP, 1'b1, 1'b1);
        expect_word("after_err_op", 32'h0020_81B3, 1'b1, 1'b0);

        // Backpressure mid-LI.
        instr_ready = 1'b0;
        send(OP_LI, 5, 0, 0, 0, 0, 32'h1234_5678);
        send(OP_LI, 5, 0, 0, 0, 0, 32'hFFFF_FFFB);
        present(OP_OP, 3, 1, 2, 0, 0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_hold", {instr_valid, instr_last, instr_err, req_ready, instr},
                  {1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_52B7});
        end
        instr_ready = 1'b1;
        send(OP_OP, 3, 1, 2, 0, 0, 32'd0);
        expect_word("bp_lui", 32'h1234_52B7, 1'b0, 1'b0);
        expect_word("bp_addi", 32'h6782_8293, 1'b1, 1'b0);
        expect_word("bp_li_small", 32'hFFB0_0293, 1'b1, 1'b0);
        expect_word("bp_op", 32'h0020_81B3, 1'b1, 1'b0);
        step();
        step();
        step();
        check("bp_no_dup", 36'(got_q.size()), 36'(0));

        // Reset while the ADDI half is pending.
        instr_ready = 1'b0;
        send(OP_LI, 5, 0, 0, 0, 0, 32'h1234_5678);
        step();
        check("emit2_pre", {3'b000, instr_valid, instr}, {3'b000, 1'b1, 32'h1234_52B7});
        rst = 1'b1;
        step();
        check("emit2_rst", {2'b00, instr_valid, req_ready, instr}, {2'b00, 1'b0, 1'b0, NOP});
        rst = 1'b0;
        instr_ready = 1'b1;
        step();
        check("emit2_ready", 36'(req_ready), 36'(1'b1));
        step();
        step();
        step();
        check("emit2_no_addi", {instr_valid, 35'(got_q.size())}, {1'b0, 35'd0});
        send(OP_LI, 5, 0, 0, 0, 0, 32'hFFFF_FFFB);
        expect_word("post_rst_li", 32'hFFB0_0293, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
